vga_palette_colorizer: RTL and testbench

- Parametrised successor to the fixed-table VGA colour assigner.
- Maps a world-map pixel plus up to ICON_LAYERS prioritised icon codes to an RGB word through a run-time-programmable palette.
- 2-stage pipeline between the pixel-address/world/icon logic and the VGA output pins.
- Palette is written and read back over a simple register port driven from the AHB/IO side; an optional frame-based blink attribute is available per palette entry.

---
 rtl/vga_palette_colorizer.sv | 131 +++++++++++++
 tb/tb_vga_palette_colorizer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_palette_colorizer.sv
// Palette-driven VGA colorizer: world pixel plus prioritised icon layers, 2-clock latency.
// Define COLORIZER_BLINK_EN to build the per-entry, vsync-counted blink attribute.
`timescale 1ns/1ps
module vga_palette_colorizer #(
  parameter int COLOR_BITS   = 4,
  parameter int WORLD_BITS   = 2,
  parameter int ICON_BITS    = 4,
  parameter int ICON_LAYERS  = 2,
  parameter int PAL_AW       = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             video_on,
  input  logic                             vsync,
  input  logic [WORLD_BITS-1:0]            world_pixel,
  input  logic [ICON_LAYERS*ICON_BITS-1:0] icon,
  input  logic                             pal_we,
  input  logic [PAL_AW-1:0]                pal_addr,
  input  logic [3*COLOR_BITS:0]            pal_wdata,
  output logic [3*COLOR_BITS:0]            pal_rdata,
  output logic [3*COLOR_BITS-1:0]          VGA
);
  localparam int RGBW   = 3 * COLOR_BITS;
  localparam int EW     = RGBW + 1;
  localparam int NWORLD = 1 << WORLD_BITS;
  localparam int NENT   = NWORLD + (1 << ICON_BITS);
  localparam int DEPTH  = 1 << PAL_AW;
  localparam int REP    = (COLOR_BITS + 3) / 4;

  typedef logic [EW-1:0] entry_t;

  // Nibble repeated MSB-first, then truncated to the channel width.
  function automatic logic [COLOR_BITS-1:0] scale(input logic [3:0] n);
    logic [4*REP-1:0] rep;
    rep = {REP{n}};
    return rep[4*REP-1 -: COLOR_BITS];
  endfunction

  function automatic entry_t def_entry(input int i);
    logic [11:0] h;
    h = 12'h000;
    if (i < NWORLD) begin
      case (i)
        0:       h = 12'hBBB;
        2:       h = 12'hF51;
        3:       h = 12'hFFF;
        default: h = 12'h000;
      endcase
    end else begin
      case (i - NWORLD)
        2:       h = 12'h00F;
        3:       h = 12'hF00;
        4:       h = 12'h3A6;
        5:       h = 12'hF51;
        6:       h = 12'h444;
        default: h = 12'h000;
      endcase
    end
    return {1'b0, scale(h[11:8]), scale(h[7:4]), scale(h[3:0])};
  endfunction

  entry_t            pal [DEPTH];
  entry_t            hit;
  logic [PAL_AW-1:0] sel;
  logic [PAL_AW-1:0] idx_q;
  logic              vld_q;
  logic              mapped;
  logic              blink_phase;

  assign mapped = int'(pal_addr) < NENT;
  assign hit    = pal[idx_q];

  // Walk from the lowest priority layer up so layer 0 overrides last.
  always_comb begin
    sel = PAL_AW'(world_pixel);
    for (int k = ICON_LAYERS - 1; k >= 0; k--) begin
      if (icon[k*ICON_BITS +: ICON_BITS] != '0)
        sel = PAL_AW'(NWORLD) + PAL_AW'(icon[k*ICON_BITS +: ICON_BITS]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        pal[i] <= (i < NENT) ? def_entry(i) : '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      pal_rdata <= '0;
      VGA       <= '0;
    end else begin
      if (pal_we && mapped)
        pal[pal_addr] <= pal_wdata;
      pal_rdata <= pal[pal_addr];
      idx_q     <= sel;
      vld_q     <= video_on;
      if (vld_q && !(hit[RGBW] && blink_phase))
        VGA <= hit[RGBW-1:0];
      else
        VGA <= '0;
    end
  end

`ifdef COLORIZER_BLINK_EN
  logic       vsync_q;
  logic [7:0] frame_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) begin
        if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end
`else
  logic unused_blink;
  assign blink_phase  = 1'b0;
  assign unused_blink = ^{vsync, 8'(BLINK_FRAMES)};
`endif

endmodule

// File: tb/tb_vga_palette_colorizer.sv
// Randomised self-checking bench for vga_palette_colorizer against a frame-level model.
`timescale 1ns/1ps
module tb_vga_palette_colorizer;
  localparam int BF = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        video_on;
  logic        vsync;
  logic [1:0]  world_pixel;
  logic [7:0]  icon;
  logic        pal_we;
  logic [4:0]  pal_addr;
  logic [12:0] pal_wdata;
  logic [12:0] pal_rdata;
  logic [11:0] VGA;

  int checks = 0;
  int errors = 0;

  logic [12:0] mpal [32];
  bit          s1_v;
  int          s1_idx;
  bit          mphase;
  int          edges;
  bit          vs_prev;
  logic [11:0] e_vga;
  logic [12:0] e_rd;

  vga_palette_colorizer #(.BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset_n(reset_n), .video_on(video_on),
    .vsync(vsync), .world_pixel(world_pixel), .icon(icon),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .pal_rdata(pal_rdata), .VGA(VGA)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mpal[i] = 13'h0;
    mpal[0]  = 13'h0BBB;
    mpal[2]  = 13'h0F51;
    mpal[3]  = 13'h0FFF;
    mpal[6]  = 13'h000F;
    mpal[7]  = 13'h0F00;
    mpal[8]  = 13'h03A6;
    mpal[9]  = 13'h0F51;
    mpal[10] = 13'h0444;
    s1_v = 0; s1_idx = 0; mphase = 0; edges = 0; vs_prev = 0;
  endtask

  function automatic int win_idx(logic [1:0] w, logic [7:0] ic);
    if (ic[3:0] != 4'h0) return 4 + int'(ic[3:0]);
    if (ic[7:4] != 4'h0) return 4 + int'(ic[7:4]);
    return int'(w);
  endfunction

  // One clock: predict outputs after this edge, then advance the model.
  task automatic step();
    @(posedge clock);
    if (!s1_v || (mpal[s1_idx][12] && mphase)) e_vga = 12'h000;
    else e_vga = mpal[s1_idx][11:0];
    e_rd = (pal_addr < 5'd20) ? mpal[pal_addr] : 13'h0;
    if (pal_we && pal_addr < 5'd20) mpal[pal_addr] = pal_wdata;
`ifdef COLORIZER_BLINK_EN
    if (vsync && !vs_prev) begin
      edges++;
      mphase = ((edges / BF) % 2) == 1;
    end
`endif
    vs_prev = vsync;
    s1_v    = video_on;
    s1_idx  = win_idx(world_pixel, icon);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (VGA !== 12'h000) begin
      errors++; $display("FAIL reset_async_vga: got %h want 000", VGA);
    end
    model_reset();
    repeat (2) begin
      @(posedge clock); #1;
      checks++;
      if (VGA !== 12'h000 || pal_rdata !== 13'h0) begin
        errors++;
        $display("FAIL reset_hold: vga %h rdata %h want 000/0000", VGA, pal_rdata);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic idle_inputs();
    video_on = 0; vsync = 0; world_pixel = 0; icon = 0;
    pal_we = 0; pal_addr = 0; pal_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    video_on = 1;
    apply_reset();
    step();
    checks++;
    if (VGA !== 12'h000) begin
      errors++; $display("FAIL latency_early: got %h want 000", VGA);
    end
    checks++;
    if (pal_rdata !== 13'h0BBB) begin
      errors++; $display("FAIL default_rd0: got %h want 0bbb", pal_rdata);
    end
    step();
    checks++;
    if (VGA !== 12'hBBB) begin
      errors++; $display("FAIL latency_world0: got %h want bbb", VGA);
    end
  endtask

  task automatic test_priority();
    world_pixel = 2; icon = 8'h30;
    step();
    icon = 8'h32;
    step();
    checks++;
    if (VGA !== 12'hF00) begin
      errors++; $display("FAIL layer1_icon: got %h want f00", VGA);
    end
    step();
    checks++;
    if (VGA !== 12'h00F) begin
      errors++; $display("FAIL layer0_wins: got %h want 00f", VGA);
    end
  endtask

  task automatic test_video_on();
    logic [11:0] want;
    world_pixel = 3; icon = 0;
    for (int i = 0; i < 8; i++) begin
      video_on = (i % 2) == 1;
      step();
      if (i >= 1) begin
        want = ((i - 1) % 2 == 1) ? 12'hFFF : 12'h000;
        checks++;
        if (VGA !== want) begin
          errors++; $display("FAIL video_on_toggle[%0d]: got %h want %h", i, VGA, want);
        end
      end
    end
  endtask

  task automatic test_write_readback();
    idle_inputs();
    video_on = 1;
    apply_reset();
    pal_we = 1; pal_addr = 0; pal_wdata = 13'h0123;
    step();
    checks++;
    if (pal_rdata !== 13'h0BBB) begin
      errors++; $display("FAIL rd_same_cycle_old: got %h want 0bbb", pal_rdata);
    end
    pal_we = 0;
    step();
    checks++;
    if (pal_rdata !== 13'h0123) begin
      errors++; $display("FAIL rd_after_write: got %h want 0123", pal_rdata);
    end
    checks++;
    if (VGA !== 12'h123) begin
      errors++; $display("FAIL world0_new_color: got %h want 123", VGA);
    end
    pal_we = 1; pal_addr = 31; pal_wdata = 13'h1FFF;
    step();
    pal_we = 0;
    step();
    checks++;
    if (pal_rdata !== 13'h0) begin
      errors++; $display("FAIL unmapped_rd: got %h want 0000", pal_rdata);
    end
  endtask

  task automatic test_same_cycle_write();
    world_pixel = 1; icon = 0; video_on = 1; pal_addr = 1;
    step(); step();
    pal_we = 1; pal_wdata = 13'h0ABC;
    step();
    pal_we = 0;
    checks++;
    if (VGA !== 12'h000) begin
      errors++; $display("FAIL same_cycle_old: got %h want 000", VGA);
    end
    step();
    checks++;
    if (VGA !== 12'hABC) begin
      errors++; $display("FAIL next_pixel_new: got %h want abc", VGA);
    end
    #2;
    apply_reset();
    step();
    checks++;
    if (pal_rdata !== 13'h0) begin
      errors++; $display("FAIL reset_restores_pal: got %h want 0000", pal_rdata);
    end
    step();
    checks++;
    if (VGA !== 12'h000) begin
      errors++; $display("FAIL reset_restores_vga: got %h want 000", VGA);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      video_on    = ($urandom % 4) != 0;
      vsync       = ($urandom % 8) == 0;
      world_pixel = 2'($urandom);
      icon[3:0]   = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      icon[7:4]   = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      pal_we      = ($urandom % 5) == 0;
      pal_addr    = 5'($urandom);
      pal_wdata   = 13'($urandom);
      step();
      checks++;
      if (VGA !== e_vga) begin
        errors++; $display("FAIL rand_vga[%0d]: got %h want %h", i, VGA, e_vga);
      end
      checks++;
      if (pal_rdata !== e_rd) begin
        errors++; $display("FAIL rand_rd[%0d]: got %h want %h", i, pal_rdata, e_rd);
      end
    end
    pal_we = 0; vsync = 0;
  endtask

  task automatic test_blink();
    int black;
    int shown;
    bit blink_built;
`ifdef COLORIZER_BLINK_EN
    blink_built = 1;
`else
    blink_built = 0;
`endif
    black = 0; shown = 0;
    idle_inputs();
    apply_reset();
    pal_we = 1; pal_addr = 5; pal_wdata = 13'h1A5C;
    step();
    pal_we = 0; video_on = 1; world_pixel = 3; icon = 8'h01;
    for (int i = 0; i < 40; i++) begin
      vsync = (i % 4) == 0;
      step();
      checks++;
      if (VGA !== e_vga) begin
        errors++; $display("FAIL blink_vga[%0d]: got %h want %h", i, VGA, e_vga);
      end
      if (i >= 1) begin
        if (VGA == 12'h000) black++;
        else if (VGA == 12'hA5C) shown++;
      end
    end
    checks++;
    if ((black > 0) !== blink_built || shown == 0) begin
      errors++;
      $display("FAIL blink_effect: black %0d shown %0d blink_built %0d", black, shown, blink_built);
    end
    vsync = 0;
  endtask

  initial begin
    reset_n = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    test_reset();
    test_priority();
    test_video_on();
    test_write_readback();
    test_same_cycle_write();
    test_random();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
